// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: registered serial sequence detector with a programmable
// pattern, selectable overlap and a saturating match counter.
// The prefix-match transition table is derived from PATTERN at elaboration
// time, so the run-time logic is only a table lookup plus a counter.

module seq_detect_fsm #(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8,
    localparam int            ST_W    = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             clear,
    output logic             match,
    output logic [ST_W-1:0]  state,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       y
);

    // Status encoding presented on y.
    typedef enum logic [1:0] {
        STAT_EMPTY   = 2'b00,
        STAT_PARTIAL = 2'b01,
        STAT_MATCH   = 2'b10,
        STAT_SAT     = 2'b11
    } status_e;

    // Table covers every encodable state value so the lookup index width
    // matches exactly; unreachable encodings fall back to the empty state.
    localparam int TAB_N = 1 << ST_W;

    // Longest k <= s+1 such that (first s pattern bits followed by b) ends
    // with the first k pattern bits. PATTERN[PAT_W-1] is the first bit.
    function automatic logic [ST_W-1:0] kmp_next(input int s, input logic b);
        logic [ST_W-1:0] best;
        logic            ok;
        logic            tbit;
        int              ti;
        best = {ST_W{1'b0}};
        for (int k = 1; k <= PAT_W; k++) begin
            if (k <= s + 1) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    ti = s + 1 - k + j;
                    if (ti == s) begin
                        tbit = b;
                    end else begin
                        tbit = PATTERN[PAT_W - 1 - ti];
                    end
                    if (tbit != PATTERN[PAT_W - 1 - j]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = ST_W'(k);
                end
            end
        end
        return best;
    endfunction

    // Longest proper border of PATTERN: the prefix already matched once a
    // full pattern has been seen and overlapping matches are allowed.
    function automatic logic [ST_W-1:0] border_len();
        logic [ST_W-1:0] best;
        logic            ok;
        best = {ST_W{1'b0}};
        for (int k = 1; k < PAT_W; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (PATTERN[PAT_W - 1 - j] != PATTERN[k - 1 - j]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = ST_W'(k);
            end
        end
        return best;
    endfunction

    localparam logic [ST_W-1:0] BORDER   = border_len();
    localparam logic [ST_W-1:0] FULL_LEN = ST_W'(PAT_W);

    logic [ST_W-1:0]  nxt0_s [TAB_N];
    logic [ST_W-1:0]  nxt1_s [TAB_N];

    logic [ST_W-1:0]  state_q;
    logic [ST_W-1:0]  state_d;
    logic             match_q;
    logic             match_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic [ST_W-1:0]  prefix_s;
    logic             count_sat_s;
    status_e          status_s;

    // Elaboration-time transition tables, one per input bit value.
    for (genvar gs = 0; gs < TAB_N; gs++) begin : g_tab
        if (gs < PAT_W) begin : g_live
            assign nxt0_s[gs] = kmp_next(gs, 1'b0);
            assign nxt1_s[gs] = kmp_next(gs, 1'b1);
        end else begin : g_unreach
            assign nxt0_s[gs] = {ST_W{1'b0}};
            assign nxt1_s[gs] = {ST_W{1'b0}};
        end
    end

    assign count_sat_s = (count_q == {CNT_W{1'b1}});

    // Prefix length reached if the current input bit were accepted.
    always_comb begin
        prefix_s = {ST_W{1'b0}};
        if (x) begin
            prefix_s = nxt1_s[state_q];
        end else begin
            prefix_s = nxt0_s[state_q];
        end
    end

    // Next-state, match pulse and counter update with clear > en > hold.
    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        count_d = count_q;
        if (clear) begin
            state_d = {ST_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else if (en) begin
            if (prefix_s == FULL_LEN) begin
                match_d = 1'b1;
                if (count_sat_s) begin
                    count_d = count_q;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
                if (OVERLAP) begin
                    state_d = BORDER;
                end else begin
                    state_d = {ST_W{1'b0}};
                end
            end else begin
                state_d = prefix_s;
            end
        end else begin
            state_d = state_q;
            count_d = count_q;
        end
    end

    // State, match pulse and counter registers; reset clears them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= {ST_W{1'b0}};
            match_q <= 1'b0;
            count_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            count_q <= count_d;
        end
    end

    // Status priority: match, then saturated counter, then partial prefix.
    always_comb begin
        status_s = STAT_EMPTY;
        if (match_q) begin
            status_s = STAT_MATCH;
        end else if (count_sat_s) begin
            status_s = STAT_SAT;
        end else if (state_q != {ST_W{1'b0}}) begin
            status_s = STAT_PARTIAL;
        end else begin
            status_s = STAT_EMPTY;
        end
    end

    assign match       = match_q;
    assign state       = state_q;
    assign match_count = count_q;
    assign y           = status_s;

    seq_detect_fsm_chk #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W),
        .ST_W  (ST_W)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .match       (match_q),
        .state       (state_q),
        .match_count (count_q),
        .y           (y)
    );

endmodule

// seq_detect_fsm_chk: structural invariants of the detector outputs.
module seq_detect_fsm_chk #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int ST_W  = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             match,
    input logic [ST_W-1:0]  state,
    input logic [CNT_W-1:0] match_count,
    input logic [1:0]       y
);

    // A full-length prefix is always consumed in the same step.
    a_state_range : assert property (@(posedge clk) disable iff (rst)
        state < ST_W'(PAT_W));

    // The match pulse always wins the status encoding.
    a_match_status : assert property (@(posedge clk) disable iff (rst)
        match |-> (y == 2'b10));

    // Saturated status only appears with a full counter.
    a_sat_status : assert property (@(posedge clk) disable iff (rst)
        (y == 2'b11) |-> (match_count == {CNT_W{1'b1}}));

endmodule
